// File: rtl/state_switch_n.sv
// One-hot sequence-state multiplexer: routes the selected channel's data, completion and
// time-base enable, with a break-before-make guard on switches and illegal-select detection.
module state_switch_n #(
  parameter int unsigned     N_CH      = 5,
  parameter int unsigned     DATA_W    = 22,
  parameter int unsigned     GUARD_CYC = 2,
  parameter logic [N_CH-1:0] OVER_MASK = 5'b01111,
  parameter int unsigned     IDX_W     = 3
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   time_up_in,
  input  logic [N_CH-1:0]        start,
  input  logic [N_CH-1:0]        state_over_in,
  input  logic [N_CH*DATA_W-1:0] datain,
  input  logic                   err_clr,
  output logic [DATA_W-1:0]      dataout,
  output logic                   state_start,
  output logic                   state_over_n,
  output logic                   over_pulse,
  output logic [N_CH-1:0]        clk_en,
  output logic [IDX_W-1:0]       active_idx,
  output logic                   switch_busy,
  output logic                   sel_err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]   guard_cnt_q, guard_cnt_d;

  logic [DATA_W-1:0]  dataout_q, dataout_d;
  logic               state_start_q, state_start_d;
  logic               state_over_n_q, state_over_n_d;
  logic               over_pulse_q, over_pulse_d;
  logic [N_CH-1:0]    clk_en_q, clk_en_d;
  logic [IDX_W-1:0]   active_idx_q, active_idx_d;
  logic               switch_busy_q, switch_busy_d;
  logic               sel_err_q, sel_err_d;

  logic               start_zero;
  logic               start_onehot;
  logic               start_illegal;
  logic [IDX_W-1:0]   start_idx;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_over_n;
  logic [N_CH-1:0]    sel_en;
  logic               run_d;

  // Classify the select vector and encode its one-hot position
  always_comb begin
    start_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (start[i]) start_idx = IDX_W'(i);
    end
    start_zero    = (start == '0);
    start_onehot  = $onehot(start);
    start_illegal = !start_zero && !start_onehot;
  end

  // Next-state logic; an illegal select overrides every state
  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    guard_cnt_d = guard_cnt_q;
    sel_err_d   = sel_err_q;

    if (err_clr) sel_err_d = 1'b0;

    if (start_illegal) begin
      state_d   = ST_IDLE;
      sel_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_onehot) begin
            state_d  = ST_RUN;
            cur_ch_d = start_idx;
          end
        end
        ST_RUN: begin
          if (start_zero) begin
            state_d = ST_IDLE;
          end else if (start_idx != cur_ch_q) begin
            cur_ch_d = start_idx;
            if (GUARD_CYC == 0) begin
              state_d = ST_RUN;
            end else begin
              state_d     = ST_GUARD;
              guard_cnt_d = CNT_W'(GUARD_CYC);
            end
          end
        end
        ST_GUARD: begin
          if (start_zero) begin
            state_d = ST_IDLE;
          end else if (start_idx != cur_ch_q) begin
            cur_ch_d    = start_idx;
            guard_cnt_d = CNT_W'(GUARD_CYC);
          end else if (guard_cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            guard_cnt_d = guard_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // View of the channel that will be running after this edge
  always_comb begin
    sel_data   = '0;
    sel_over_n = 1'b1;
    sel_en     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cur_ch_d == IDX_W'(i)) begin
        sel_data   = datain[i*DATA_W +: DATA_W];
        sel_over_n = OVER_MASK[i] ? state_over_in[i] : 1'b1;
        sel_en[i]  = time_up_in;
      end
    end
  end

  // Output next values; everything parks at reset values outside RUN
  always_comb begin
    run_d          = (state_d == ST_RUN);
    dataout_d      = run_d ? sel_data : '0;
    state_start_d  = run_d;
    state_over_n_d = run_d ? sel_over_n : 1'b1;
    clk_en_d       = run_d ? sel_en : '0;
    active_idx_d   = run_d ? cur_ch_d : '0;
    switch_busy_d  = (state_d == ST_GUARD);
    // Pulse only on a fall within an uninterrupted run of one channel
    over_pulse_d   = (state_q == ST_RUN) && run_d && (cur_ch_d == cur_ch_q) &&
                     state_over_n_q && !state_over_n_d;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cur_ch_q       <= '0;
      guard_cnt_q    <= '0;
      dataout_q      <= '0;
      state_start_q  <= 1'b0;
      state_over_n_q <= 1'b1;
      over_pulse_q   <= 1'b0;
      clk_en_q       <= '0;
      active_idx_q   <= '0;
      switch_busy_q  <= 1'b0;
      sel_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_ch_q       <= cur_ch_d;
      guard_cnt_q    <= guard_cnt_d;
      dataout_q      <= dataout_d;
      state_start_q  <= state_start_d;
      state_over_n_q <= state_over_n_d;
      over_pulse_q   <= over_pulse_d;
      clk_en_q       <= clk_en_d;
      active_idx_q   <= active_idx_d;
      switch_busy_q  <= switch_busy_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign dataout      = dataout_q;
  assign state_start  = state_start_q;
  assign state_over_n = state_over_n_q;
  assign over_pulse   = over_pulse_q;
  assign clk_en       = clk_en_q;
  assign active_idx   = active_idx_q;
  assign switch_busy  = switch_busy_q;
  assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_state_switch_n.sv
// Scoreboard bench for state_switch_n: one instance with a 2-cycle guard, one with no guard.
module tb_state_switch_n;

  localparam int unsigned N_CH   = 5;
  localparam int unsigned DATA_W = 22;
  localparam int unsigned IDX_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] dataout;
    logic              state_start;
    logic              state_over_n;
    logic              over_pulse;
    logic [N_CH-1:0]   clk_en;
    logic [IDX_W-1:0]  active_idx;
    logic              switch_busy;
    logic              sel_err;
  } obs_t;

  logic                   clk_sys = 1'b0;
  logic                   rst_n;
  logic                   time_up_in;
  logic [N_CH-1:0]        start;
  logic [N_CH-1:0]        state_over_in;
  logic [N_CH*DATA_W-1:0] datain;
  logic                   err_clr;

  logic [DATA_W-1:0] dout_g, dout_z;
  logic              ss_g, ss_z, ovn_g, ovn_z, pls_g, pls_z, busy_g, busy_z, err_g, err_z;
  logic [N_CH-1:0]   en_g, en_z;
  logic [IDX_W-1:0]  idx_g, idx_z;
  obs_t              obs_g, obs_z;

  logic [DATA_W-1:0] dat [N_CH];

  obs_t  exp_q [$];
  bit    sel_q [$];
  string name_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  state_switch_n #(.N_CH(N_CH), .DATA_W(DATA_W), .GUARD_CYC(2),
                   .OVER_MASK(5'b01111), .IDX_W(IDX_W)) dut_g (
    .clk_sys(clk_sys), .rst_n(rst_n), .time_up_in(time_up_in), .start(start),
    .state_over_in(state_over_in), .datain(datain), .err_clr(err_clr),
    .dataout(dout_g), .state_start(ss_g), .state_over_n(ovn_g), .over_pulse(pls_g),
    .clk_en(en_g), .active_idx(idx_g), .switch_busy(busy_g), .sel_err(err_g));

  state_switch_n #(.N_CH(N_CH), .DATA_W(DATA_W), .GUARD_CYC(0),
                   .OVER_MASK(5'b01111), .IDX_W(IDX_W)) dut_z (
    .clk_sys(clk_sys), .rst_n(rst_n), .time_up_in(time_up_in), .start(start),
    .state_over_in(state_over_in), .datain(datain), .err_clr(err_clr),
    .dataout(dout_z), .state_start(ss_z), .state_over_n(ovn_z), .over_pulse(pls_z),
    .clk_en(en_z), .active_idx(idx_z), .switch_busy(busy_z), .sel_err(err_z));

  assign obs_g = {dout_g, ss_g, ovn_g, pls_g, en_g, idx_g, busy_g, err_g};
  assign obs_z = {dout_z, ss_z, ovn_z, pls_z, en_z, idx_z, busy_z, err_z};

  function automatic obs_t e_idle(input logic err);
    obs_t o;
    o = '0;
    o.state_over_n = 1'b1;
    o.sel_err = err;
    return o;
  endfunction

  function automatic obs_t e_guard(input logic err);
    obs_t o;
    o = e_idle(err);
    o.switch_busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_run(input int ch, input logic ovn, input logic pls,
                                 input logic tup, input logic err);
    obs_t o;
    o = '0;
    o.dataout      = dat[ch];
    o.state_start  = 1'b1;
    o.state_over_n = ovn;
    o.over_pulse   = pls;
    o.clk_en       = N_CH'(tup) << ch;
    o.active_idx   = IDX_W'(ch);
    o.sel_err      = err;
    return o;
  endfunction

  // Queue the response expected after the next active edge, then move to the next cycle
  task automatic tick(input obs_t e, input string n, input bit s = 1'b0);
    exp_q.push_back(e);
    sel_q.push_back(s);
    name_q.push_back(n);
    @(negedge clk_sys);
  endtask

  // Monitor: every registered output update is checked against the oldest expectation
  always @(posedge clk_sys) begin
    #2;
    if (exp_q.size() != 0) begin
      obs_t  e;
      obs_t  a;
      bit    s;
      string n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = s ? obs_z : obs_g;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got data=%h st=%b ovn=%b pls=%b en=%b idx=%0d busy=%b err=%b | required data=%h st=%b ovn=%b pls=%b en=%b idx=%0d busy=%b err=%b",
                 n, a.dataout, a.state_start, a.state_over_n, a.over_pulse, a.clk_en,
                 a.active_idx, a.switch_busy, a.sel_err, e.dataout, e.state_start,
                 e.state_over_n, e.over_pulse, e.clk_en, e.active_idx, e.switch_busy, e.sel_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    dat[0] = 22'h011111;
    dat[1] = 22'(20'hABCDE);
    dat[2] = 22'h222222;
    dat[3] = 22'h333333;
    dat[4] = 22'h044444;
    for (int i = 0; i < N_CH; i++) datain[i*DATA_W +: DATA_W] = dat[i];

    rst_n = 1'b0; start = '0; time_up_in = 1'b0; state_over_in = '1; err_clr = 1'b0;
    tick(e_idle(0), "reset");

    rst_n = 1'b1; start = 5'b00010;
    tick(e_run(1, 1, 0, 0, 0), "start_ch1");
    start = 5'b00000;
    tick(e_idle(0), "to_idle");
    start = 5'b00001;
    tick(e_run(0, 1, 0, 0, 0), "run_ch0");
    for (int i = 0; i < 8; i++) begin
      time_up_in = (i == 3 || i == 7);
      tick(e_run(0, 1, 0, (i == 3 || i == 7), 0), "tick_gate");
    end

    // Guard interval: time base held high to show it is gated off
    time_up_in = 1'b1; start = 5'b00100;
    tick(e_guard(0), "guard_a");
    tick(e_guard(0), "guard_b");
    tick(e_run(2, 1, 0, 1, 0), "guard_done");
    time_up_in = 1'b0;
    tick(e_run(2, 1, 0, 0, 0), "run_ch2");

    start = 5'b01000;
    tick(e_guard(0), "guard_c");
    tick(e_guard(0), "guard_d");
    tick(e_run(3, 1, 0, 0, 0), "run_ch3");
    state_over_in = 5'b10111;
    tick(e_run(3, 0, 1, 0, 0), "over_fall");
    tick(e_run(3, 0, 0, 0, 0), "over_hold");
    tick(e_run(3, 0, 0, 0, 0), "over_hold2");

    start = 5'b10000; state_over_in = 5'b00111;
    tick(e_guard(0), "guard_e");
    tick(e_guard(0), "guard_f");
    tick(e_run(4, 1, 0, 0, 0), "masked");
    tick(e_run(4, 1, 0, 0, 0), "masked_hold");
    state_over_in = '1;

    start = 5'b00011;
    tick(e_idle(1), "illegal");
    start = 5'b00000;
    tick(e_idle(1), "err_sticky");
    err_clr = 1'b1; start = 5'b00101;
    tick(e_idle(1), "clr_vs_set");
    start = 5'b00000;
    tick(e_idle(0), "err_clr");
    err_clr = 1'b0;

    start = 5'b00001;
    tick(e_run(0, 1, 0, 0, 0), "run_ch0_b");
    start = 5'b11000;
    tick(e_idle(1), "illegal_run");
    start = 5'b00001;
    tick(e_run(0, 1, 0, 0, 1), "reentry");
    err_clr = 1'b1;
    tick(e_run(0, 1, 0, 0, 0), "clr_in_run");
    err_clr = 1'b0;

    start = 5'b00010;
    tick(e_guard(0), "guard_ch1");
    start = 5'b00100;
    tick(e_guard(0), "retarget");
    tick(e_guard(0), "reload");
    tick(e_run(2, 1, 0, 0, 0), "retarget_done");

    start = 5'b00001;
    tick(e_guard(0), "guard_ch0");
    start = 5'b00010;
    tick(e_guard(0), "retarget2");
    rst_n = 1'b0;
    tick(e_idle(0), "rst_guard");
    rst_n = 1'b1; start = 5'b00000;
    tick(e_idle(0), "post_rst_idle");
    start = 5'b00010;
    tick(e_run(1, 1, 0, 0, 0), "post_rst_run");

    start = 5'b00011;
    tick(e_idle(1), "illegal_b");
    start = 5'b00001;
    tick(e_run(0, 1, 0, 0, 1), "reentry_b");
    rst_n = 1'b0;
    tick(e_idle(0), "rst_clears_err");
    rst_n = 1'b1; start = 5'b00000;
    tick(e_idle(0), "idle_after_rst");

    // Zero-guard instance: direct switches
    rst_n = 1'b0;
    tick(e_idle(0), "z_reset", 1'b1);
    rst_n = 1'b1; start = 5'b00001;
    tick(e_run(0, 1, 0, 0, 0), "z_run0", 1'b1);
    start = 5'b00100;
    tick(e_run(2, 1, 0, 0, 0), "z_switch", 1'b1);
    tick(e_run(2, 1, 0, 0, 0), "z_hold2", 1'b1);
    start = 5'b00010; state_over_in = 5'b11101;
    tick(e_run(1, 0, 0, 0, 0), "z_switch_no_pulse", 1'b1);
    tick(e_run(1, 0, 0, 0, 0), "z_hold1", 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk_sys);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/state_switch_n.md
Name: state_switch_n

Overview:
Parametrised successor to the NMR sequencer's one-hot state multiplexer. It selects one of N_CH sequence-state channels (scale, scan, noise, pulse, 1 ms, ...). It routes that channel's data word, completion flag and time-base clock enable. New behaviour: a break-before-make guard interval on channel-to-channel switches, detection of illegal (non-one-hot) selects, and a one-cycle completion pulse.

Parameters:
N_CH, 5, number of state channels (2..16)
DATA_W, 22, width of each channel data word and of dataout; narrower sources are zero-extended by the instantiator
GUARD_CYC, 2, idle cycles inserted on a direct channel-to-channel switch (0..15; 0 = no guard)
OVER_MASK, 5'b01111, N_CH bits; bit i=1 means channel i drives a state_over_in bit, bit i=0 forces completion to 1 (never done)
IDX_W, 3, width of active_idx, must be >= clog2(N_CH)

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset
time_up_in  in  1  time-base tick, gated to the active channel
start  in  N_CH  one-hot channel select; all-zero = idle
state_over_in  in  N_CH  per-channel completion, active-low
datain  in  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W]
err_clr  in  1  clears sel_err
dataout  out  DATA_W  selected channel data
state_start  out  1  high while a channel is running
state_over_n  out  1  active-low completion of the running channel
over_pulse  out  1  one-cycle pulse on 1->0 of state_over_n within one run
clk_en  out  N_CH  gated time_up_in; only the active bit can be 1
active_idx  out  IDX_W  binary index of the running channel; 0 when idle
switch_busy  out  1  high during the guard interval
sel_err  out  1  sticky illegal-select flag

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk_sys. All outputs are registered.
- Reset values:
  - dataout=0, state_start=0, state_over_n=1, over_pulse=0
  - clk_en=0, active_idx=0, switch_busy=0, sel_err=0
  - FSM=IDLE
- FSM states: IDLE, GUARD, RUN. cur_ch register holds the running or target channel.
- IDLE:
  - Outputs are at their reset values except sel_err.
  - Valid one-hot start[i] sampled at edge t -> RUN on channel i. Outputs reflect channel i at edge t (1-cycle latency, same as the legacy block).
- RUN, each cycle:
  - dataout <= datain[cur_ch]
  - state_over_n <= OVER_MASK[cur_ch] ? state_over_in[cur_ch] : 1
  - clk_en[cur_ch] <= time_up_in; other bits 0
  - state_start <= 1
  - active_idx <= cur_ch
- RUN transitions:
  - start unchanged -> stay in RUN.
  - start == 0 -> IDLE; outputs return to reset values at the same edge.
  - start one-hot, different channel j:
    - If GUARD_CYC == 0: switch directly, new channel's outputs at that edge.
    - Else: GUARD with target j and guard counter = GUARD_CYC. At that edge dataout=0, clk_en=0, state_start=0, state_over_n=1, switch_busy=1.
- GUARD:
  - Counter decrements each cycle.
  - When it expires, RUN on target. First RUN outputs appear exactly GUARD_CYC edges after the switch edge.
  - start changes to a different valid channel -> retarget and reload the counter.
  - start == 0 -> IDLE.
- Illegal start (more than one bit set), in any state:
  - Go to IDLE with outputs at reset values.
  - sel_err <= 1.
  - Re-entry requires a valid one-hot start.
- sel_err:
  - Cleared by err_clr.
  - If err_clr and a new illegal select occur on the same edge, the set wins.
- over_pulse:
  - 1 for exactly one cycle when registered state_over_n goes 1->0 while in RUN on the same cur_ch.
  - No pulse on switch, on idle, or when the masked-off channel reports completion.
- Reset asserted mid-RUN or mid-GUARD: all state returns to reset values on that edge. A pending guard is discarded.

Test Plan:
- Reset then start=5'b00010, datain ch1=20'hABCDE -> next edge: dataout=22'h0ABCDE, state_start=1, active_idx=1, switch_busy=0.
- RUN ch0, time_up_in pulses on cycles 3 and 7 -> clk_en=5'b00001 one cycle after each tick; all other clk_en bits stay 0.
- RUN ch0, start->5'b00100 with GUARD_CYC=2 -> 2 cycles of dataout=0, state_start=0, switch_busy=1, then ch2 data, active_idx=2. Repeat with GUARD_CYC=0 -> switch with no gap.
- RUN ch3, state_over_in[3] 1->0 and held -> state_over_n=0 next edge; over_pulse high for exactly one cycle. Select ch4 with state_over_in[4]=0 -> state_over_n stays 1 (masked).
- start=5'b00011 -> IDLE outputs, sel_err=1 and held after start=0. err_clr with start=5'b00101 on the same edge -> sel_err stays 1.
- During GUARD toward ch1, retarget to ch2, then assert rst_n=0 -> guard reloads to GUARD_CYC on retarget; after reset all outputs at reset values and FSM=IDLE.
